// File: rtl/alu_sequencer.sv
// Time-shares one ALU to compute R = A*x + B*y +/- C; start accepted in IDLE/DONE, done pulses 5 cycles later.
// No backpressure: start during MUL0..ADD1 is ignored, back-to-back starts from DONE run with no bubble.
module alu_sequencer #(
    parameter int             n      = 8,
    parameter logic [n-1:0]   COEF_A = n'(3),
    parameter logic [n-1:0]   COEF_B = n'(5),
    parameter logic [n-1:0]   COEF_C = n'(7),
    parameter logic           SUB_C  = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] x_in,
    input  logic [n-1:0] y_in,
    input  logic [n-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [2:0]   alu_func,
    output logic [1:0]   alu_a_sel,
    output logic [1:0]   alu_b_sel,
    output logic         alu_imm,
    output logic [n-1:0] alu_immediate,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result_out,
    output logic         carry_out
);

    // ALU function and operand-select encodings (alucodes)
    localparam logic [2:0] RA    = 3'b000;
    localparam logic [2:0] RADD  = 3'b010;
    localparam logic [2:0] RSUB  = 3'b011;
    localparam logic [2:0] RMULL = 3'b110;
    localparam logic [1:0] REG   = 2'b00;

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, ADD0, ADD1, DONE} state_t;

    state_t       state, state_nxt;
    logic [n-1:0] x_reg, y_reg, acc, tmp;
    logic         unused_flags;

    assign unused_flags = ^alu_flags[3:1];
    assign alu_a_sel    = REG;
    assign alu_b_sel    = REG;
    assign busy         = (state == MUL0) || (state == MUL1) || (state == ADD0) || (state == ADD1);
    assign done         = (state == DONE);

    always_comb begin
        state_nxt     = state;
        alu_func      = RA;
        alu_a         = '0;
        alu_b         = '0;
        alu_imm       = 1'b0;
        alu_immediate = '0;
        case (state)
            IDLE: if (start) state_nxt = MUL0;
            MUL0: begin
                alu_func      = RMULL;
                alu_a         = x_reg;
                alu_imm       = 1'b1;
                alu_immediate = COEF_A;
                state_nxt     = MUL1;
            end
            MUL1: begin
                alu_func      = RMULL;
                alu_a         = y_reg;
                alu_imm       = 1'b1;
                alu_immediate = COEF_B;
                state_nxt     = ADD0;
            end
            ADD0: begin
                alu_func  = RADD;
                alu_a     = acc;
                alu_b     = tmp;
                state_nxt = ADD1;
            end
            ADD1: begin
                alu_func      = SUB_C ? RSUB : RADD;
                alu_a         = acc;
                alu_imm       = 1'b1;
                alu_immediate = COEF_C;
                state_nxt     = DONE;
            end
            DONE:    state_nxt = start ? MUL0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x_reg      <= '0;
            y_reg      <= '0;
            acc        <= '0;
            tmp        <= '0;
            result_out <= '0;
            carry_out  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x_reg     <= x_in;
                        y_reg     <= y_in;
                        carry_out <= 1'b0;
                    end
                end
                MUL0: acc <= alu_result;
                MUL1: tmp <= alu_result;
                ADD0: begin
                    acc       <= alu_result;
                    carry_out <= carry_out | alu_flags[0];
                end
                ADD1: begin
                    result_out <= alu_result;
                    // the subtract step's C flag is a borrow indicator, not an overflow carry
                    if (!SUB_C) carry_out <= carry_out | alu_flags[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that time-shares the single picoMIPS ALU to evaluate the affine term R = A·x + B·y + C (8-bit, modulo 2^n).
- A/B/C are compile-time coefficients.
- Sits between the operand source (switch/regfile logic) and the combinational `alu` instance, driving its function, select and operand inputs and capturing its result/flags each cycle.
- Start/busy/done handshake to the surrounding control.

Parameters:
- n, 8, datapath width (must match the ALU's n)
- COEF_A, 8'd3, multiplier applied to x
- COEF_B, 8'd5, multiplier applied to y
- COEF_C, 8'd7, constant term
- SUB_C, 1'b0, 1 = subtract C instead of adding it

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- x_in  in  n  operand x, latched when start is accepted
- y_in  in  n  operand y, latched when start is accepted
- alu_result  in  n  ALU result (combinational return path)
- alu_flags  in  4  ALU flags {V,N,Z,C}
- alu_a  out  n  to ALU a_in
- alu_b  out  n  to ALU b_in
- alu_func  out  3  to ALU func, `alucodes.sv` encodings
- alu_a_sel  out  2  to ALU a_sel; always `REG
- alu_b_sel  out  2  to ALU b_sel; always `REG
- alu_imm  out  1  to ALU imm
- alu_immediate  out  n  to ALU immediate
- busy  out  1  high in MUL0..ADD1
- done  out  1  one-cycle pulse, result valid
- result_out  out  n  final R; held until the next accepted start completes
- carry_out  out  1  sticky unsigned carry from either add step

Behaviour:
- States: IDLE, MUL0, MUL1, ADD0, ADD1, DONE. Registered FSM; ALU outputs are decoded combinationally from state.
- Reset (sync, priority over everything): state=IDLE, x/y/acc/tmp regs=0, result_out=0, carry_out=0, busy=0, done=0.
- Idle outputs (IDLE/DONE): alu_func=`RA, imm=0, immediate=0, alu_a=alu_b=0.
- IDLE: start=1 → latch x_in, y_in; clear carry_out; go to MUL0. start=0 → stay.
- MUL0: func=`RMULL, a=x, imm=1, immediate=COEF_A. At the clock edge acc ← alu_result. → MUL1.
- MUL1: func=`RMULL, a=y, imm=1, immediate=COEF_B. tmp ← alu_result. → ADD0.
- ADD0: func=`RADD, a=acc, b=tmp, imm=0. acc ← alu_result; carry_out |= alu_flags[0]. → ADD1.
- ADD1: func=`RADD (SUB_C=0) or `RSUB (SUB_C=1), a=acc, imm=1, immediate=COEF_C. result_out ← alu_result. If SUB_C=0, carry_out |= alu_flags[0]. → DONE.
- DONE: done=1 for exactly this cycle. start=1 → accept as in IDLE (back-to-back, no bubble) and go to MUL0. Otherwise → IDLE.
- start in MUL0..ADD1 is ignored; no queuing.
- Latency: start accepted at edge k → done high in cycle k+4..k+5 (5th state after IDLE). Throughput is one result per 5 cycles.
- Arithmetic: products are truncated to the low n bits; all sums are modulo 2^n. Signed overflow (V) is not tracked.
- x_in/y_in changes after acceptance have no effect.
- result_out changes only at the ADD1 edge.
- Reset asserted mid-sequence aborts it: the next cycle is IDLE, outputs are at reset values, and no done is issued.

Test Plan:
- Defaults, x=2, y=4, start 1 cycle → busy 4 cycles, then done 1 cycle; result_out=33 (6+20+7), carry_out=0.
- x=50, y=40 → products 150, 200; ADD0 carry; result_out=101 (0x5E+7), carry_out=1.
- Per-state ALU drive check, x=2, y=4: MUL0 func=`RMULL, imm=1, immediate=3, a=2. ADD0 func=`RADD, imm=0, a=6, b=20. a_sel=b_sel=`REG in every state.
- start held high continuously with x=1, y=1 → result_out=15 each pass; done every 5th cycle; no IDLE gap between runs. Toggling x_in mid-run does not change the result.
- reset asserted during ADD0, then deasserted → next cycle IDLE, result_out=0, done never pulses. A new start with x=2, y=4 completes with 33.
- SUB_C=1, x=2, y=4 → result_out=19 (26-7). carry_out unaffected by ADD1.
